bus_demux3: RTL and testbench

// - Data-side bus splitter: routes one core load/store request to one of three memory-mapped targets.

---
 rtl/bus_demux3_pkg.sv | 25 ++
 rtl/bus_demux3_if.sv | 31 +++
 rtl/bus_demux3_addr_decode3.sv | 32 +++
 rtl/mux3.sv | 21 ++
 rtl/bus_demux3.sv | 130 +++++++++++++
 tb/tb_bus_demux3.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/bus_demux3_pkg.sv
// Shared definitions for the data-side bus splitter: FSM states, target indices, one-hot helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] TGT_RAM  = 2'd0;
  localparam logic [1:0] TGT_MMIO = 2'd1;
  localparam logic [1:0] TGT_TMR  = 2'd2;

  function automatic logic [2:0] tgt_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      TGT_RAM:  oh = 3'b001;
      TGT_MMIO: oh = 3'b010;
      TGT_TMR:  oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bus_demux3_if.sv
// Core-side request/response plus shared target-side bus; slave = splitter view, master = core/targets view.
interface bus_demux3_if #(
  parameter int WIDTH = 32
);
  logic             c_req;
  logic             c_we;
  logic [WIDTH-1:0] c_addr;
  logic [WIDTH-1:0] c_wdata;
  logic [WIDTH-1:0] c_rdata;
  logic             c_ready;
  logic             c_err;
  logic [2:0]       t_req;
  logic             t_we;
  logic [WIDTH-1:0] t_addr;
  logic [WIDTH-1:0] t_wdata;
  logic [2:0]       t_ready;
  logic [WIDTH-1:0] t_rdata0;
  logic [WIDTH-1:0] t_rdata1;
  logic [WIDTH-1:0] t_rdata2;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, t_ready, t_rdata0, t_rdata1, t_rdata2,
    output c_rdata, c_ready, c_err, t_req, t_we, t_addr, t_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, t_ready, t_rdata0, t_rdata1, t_rdata2,
    input  c_rdata, c_ready, c_err, t_req, t_we, t_addr, t_wdata
  );

endinterface

// File: rtl/bus_demux3_addr_decode3.sv
// Combinational mask/compare address decoder; overlapping windows resolve to the lowest target index.
module addr_decode3
  import bus_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] BASE0 = 32'h00000000,
  parameter logic [WIDTH-1:0] MASK0 = 32'hFFFFF000,
  parameter logic [WIDTH-1:0] BASE1 = 32'h10000000,
  parameter logic [WIDTH-1:0] MASK1 = 32'hFFFFFF00,
  parameter logic [WIDTH-1:0] BASE2 = 32'h20000000,
  parameter logic [WIDTH-1:0] MASK2 = 32'hFFFFFFF0
) (
  input  logic [WIDTH-1:0] i_addr,
  output logic             o_hit,
  output logic [1:0]       o_idx
);

  always_comb begin
    o_hit = 1'b1;
    o_idx = TGT_RAM;
    if ((i_addr & MASK0) == BASE0) begin
      o_idx = TGT_RAM;
    end else if ((i_addr & MASK1) == BASE1) begin
      o_idx = TGT_MMIO;
    end else if ((i_addr & MASK2) == BASE2) begin
      o_idx = TGT_TMR;
    end else begin
      o_hit = 1'b0;
    end
  end

endmodule

// File: rtl/mux3.sv
// Three-way data mux with binary select; select 2'b11 returns zero.
module mux3 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      2'b10:   o_y = i_d2;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/bus_demux3.sv
// Routes one core load/store to RAM/MMIO/timer; c_ready 1 cycle after sample if unmapped, 2+waits on hit,
// TIMEOUT+1 on timeout. Core holds its request until c_ready; new requests are sampled only in IDLE.
module bus_demux3
  import bus_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] BASE0   = 32'h00000000,
  parameter logic [WIDTH-1:0] MASK0   = 32'hFFFFF000,
  parameter logic [WIDTH-1:0] BASE1   = 32'h10000000,
  parameter logic [WIDTH-1:0] MASK1   = 32'hFFFFFF00,
  parameter logic [WIDTH-1:0] BASE2   = 32'h20000000,
  parameter logic [WIDTH-1:0] MASK2   = 32'hFFFFFFF0,
  parameter int               TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  bus_demux3_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_t_req;
  logic             r_t_we;
  logic [WIDTH-1:0] r_t_addr;
  logic [WIDTH-1:0] r_t_wdata;
  logic [WIDTH-1:0] r_c_rdata;
  logic             r_c_ready;
  logic             r_c_err;

  logic             w_hit;
  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_rdata_sel;
  logic             w_sel_ready;

  addr_decode3 #(
    .WIDTH(WIDTH),
    .BASE0(BASE0), .MASK0(MASK0),
    .BASE1(BASE1), .MASK1(MASK1),
    .BASE2(BASE2), .MASK2(MASK2)
  ) u_decode (
    .i_addr (bus.c_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  mux3 #(.WIDTH(WIDTH)) u_rdata_mux (
    .i_sel (r_tgt),
    .i_d0  (bus.t_rdata0),
    .i_d1  (bus.t_rdata1),
    .i_d2  (bus.t_rdata2),
    .o_y   (w_rdata_sel)
  );

  // r_t_req is non-zero only in BUSY, so this masks both unselected and out-of-state readies.
  assign w_sel_ready = |(bus.t_ready & r_t_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tgt     <= TGT_RAM;
      r_cnt     <= '0;
      r_t_req   <= 3'b000;
      r_t_we    <= 1'b0;
      r_t_addr  <= '0;
      r_t_wdata <= '0;
      r_c_rdata <= '0;
      r_c_ready <= 1'b0;
      r_c_err   <= 1'b0;
    end else begin
      r_c_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.c_req) begin
            if (w_hit) begin
              r_t_we    <= bus.c_we;
              r_t_addr  <= bus.c_addr;
              r_t_wdata <= bus.c_wdata;
              r_tgt     <= w_idx;
              r_t_req   <= tgt_onehot(w_idx);
              r_cnt     <= '0;
              r_state   <= BUSY;
            end else begin
              r_c_err   <= 1'b1;
              r_c_rdata <= '0;
              r_c_ready <= 1'b1;
              r_state   <= RESP;
            end
          end
        end
        BUSY: begin
          // Ready is checked first so a ready on the last allowed cycle beats the timeout.
          if (w_sel_ready) begin
            r_t_req   <= 3'b000;
            r_c_rdata <= r_t_we ? '0 : w_rdata_sel;
            r_c_err   <= 1'b0;
            r_c_ready <= 1'b1;
            r_state   <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_t_req   <= 3'b000;
            r_c_rdata <= '0;
            r_c_err   <= 1'b1;
            r_c_ready <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.t_req   = r_t_req;
  assign bus.t_we    = r_t_we;
  assign bus.t_addr  = r_t_addr;
  assign bus.t_wdata = r_t_wdata;
  assign bus.c_rdata = r_c_rdata;
  assign bus.c_ready = r_c_ready;
  assign bus.c_err   = r_c_err;

endmodule

// File: tb/tb_bus_demux3.sv
// Self-checking bench for bus_demux3: directed scenarios plus randomized traffic against a transaction-level model.
module tb_bus_demux3;

  localparam int          WIDTH   = 32;
  localparam int          TIMEOUT = 15;
  localparam logic [31:0] B0 = 32'h00000000, M0 = 32'hFFFFF000;
  localparam logic [31:0] B1 = 32'h10000000, M1 = 32'hFFFFFF00;
  localparam logic [31:0] B2 = 32'h20000000, M2 = 32'hFFFFFFF0;
  localparam int          NEVER = 255;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  bus_demux3_if #(.WIDTH(WIDTH)) bus ();

  bus_demux3 #(
    .WIDTH(WIDTH),
    .BASE0(B0), .MASK0(M0),
    .BASE1(B1), .MASK1(M1),
    .BASE2(B2), .MASK2(M2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: which target an address maps to, -1 when unmapped.
  function automatic int ref_target(input logic [31:0] a);
    if ((a & M0) == B0) return 0;
    if ((a & M1) == B1) return 1;
    if ((a & M2) == B2) return 2;
    return -1;
  endfunction

  // One transaction; the target asserts ready after wait_n wait-states (NEVER = no ready).
  // Called at a negedge. b2b: the previous call left c_req high in its RESP cycle.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n, input bit stray,
                         input bit b2b, input bit hold);
    int          k, exp_lat, exp_req, lat, req_cyc, bad_req, bad_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [2:0]  rdy;
    k      = ref_target(addr);
    exp_rd = '0;
    if (k < 0) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (wait_n < TIMEOUT) begin
      exp_lat = wait_n + 2;
      exp_err = 1'b0;
      if (!we) exp_rd = (k == 0) ? bus.t_rdata0 : (k == 1) ? bus.t_rdata1 : bus.t_rdata2;
    end else begin
      exp_lat = TIMEOUT + 1;
      exp_err = 1'b1;
    end
    exp_req = (k < 0) ? 0 : exp_lat - 1;

    bus.c_req   = 1'b1;
    bus.c_we    = we;
    bus.c_addr  = addr;
    bus.c_wdata = wdata;
    bus.t_ready = 3'b000;
    if (b2b) begin
      @(negedge clk);
      vectors++;
      if ({bus.c_ready, bus.t_req} !== 4'b0000) begin
        miscompares++;
        $display("FAIL %s resp_gap: c_ready/t_req got %b/%b want 0/000", name, bus.c_ready, bus.t_req);
      end
    end

    lat = 0; req_cyc = 0; bad_req = 0; bad_lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.t_req !== 3'b000) begin
        if (k >= 0 && bus.t_req === (3'b001 << k)) req_cyc++;
        else bad_req++;
        if (bus.t_we !== we || bus.t_addr !== addr || bus.t_wdata !== wdata) bad_lat++;
      end
      if (bus.c_ready === 1'b1) begin
        lat = n;
      end else begin
        rdy = stray ? 3'($urandom) : 3'b000;
        if (k >= 0) rdy[k] = (n == wait_n + 1);
        bus.t_ready = rdy;
      end
    end
    bus.t_ready = 3'b000;

    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d (addr %h)", name, lat, exp_lat, addr);
    end
    vectors++;
    if (bus.c_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s c_err: got %b want %b (addr %h)", name, bus.c_err, exp_err, addr);
    end
    vectors++;
    if (bus.c_rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL %s c_rdata: got %h want %h (addr %h)", name, bus.c_rdata, exp_rd, addr);
    end
    vectors++;
    if (req_cyc != exp_req || bad_req != 0) begin
      miscompares++;
      $display("FAIL %s t_req: got %0d good cycles, %0d wrong want %0d good, 0 wrong",
               name, req_cyc, bad_req, exp_req);
    end
    vectors++;
    if (bad_lat != 0) begin
      miscompares++;
      $display("FAIL %s t_bus: got %0d cycles with wrong t_we/t_addr/t_wdata want 0", name, bad_lat);
    end

    if (!hold) begin
      bus.c_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.c_ready !== 1'b0 || bus.c_err !== exp_err || bus.c_rdata !== exp_rd) begin
        miscompares++;
        $display("FAIL %s after_resp: c_ready/c_err/c_rdata got %b/%b/%h want 0/%b/%h",
                 name, bus.c_ready, bus.c_err, bus.c_rdata, exp_err, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.t_ready = 3'b000; bus.t_rdata0 = '0; bus.t_rdata1 = '0; bus.t_rdata2 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.c_rdata, bus.c_ready, bus.c_err, bus.t_req, bus.t_we, bus.t_addr, bus.t_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: c_ready/c_err/t_req/t_addr got %b/%b/%b/%h want all zero",
               bus.c_ready, bus.c_err, bus.t_req, bus.t_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_ram();
    bus.t_rdata0 = 32'hDEADBEEF; bus.t_rdata1 = 32'h11111111; bus.t_rdata2 = 32'h22222222;
    run_txn("load_ram", 1'b0, 32'h00000010, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_store_mmio_wait();
    bus.t_rdata1 = 32'hCAFEF00D;
    run_txn("store_mmio", 1'b1, 32'h10000004, 32'h0000005A, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn("unmapped", 1'b0, 32'h30000000, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 32'h20000000, 32'h0, NEVER, 1'b0, 1'b0, 1'b0);
    bus.t_rdata2 = 32'h0BADC0DE;
    run_txn("ready_at_timeout", 1'b0, 32'h20000008, 32'h0, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stray_ready();
    bus.t_rdata0 = 32'h12345678;
    run_txn("stray_ready", 1'b0, 32'h00000100, 32'h0, 4, 1'b1, 1'b0, 1'b0);
    bus.t_rdata1 = 32'h87654321;
    run_txn("stray_ready_mmio", 1'b0, 32'h10000020, 32'h0, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_decode_boundaries();
    logic [31:0] addrs [0:5];
    addrs = '{32'h00000FFC, 32'h00001000, 32'h100000FF, 32'h10000100, 32'h2000000F, 32'h20000010};
    for (int i = 0; i < 6; i++) begin
      bus.t_rdata0 = $urandom; bus.t_rdata1 = $urandom; bus.t_rdata2 = $urandom;
      run_txn("decode_boundary", 1'b0, addrs[i], 32'h0, 1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_busy();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h00000040; bus.c_wdata = 32'hA5A5A5A5;
    bus.t_ready = 3'b000;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.t_req, bus.c_ready, bus.c_err, bus.t_we, bus.t_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_busy: t_req/c_ready/t_we/t_addr got %b/%b/%b/%h want 000/0/0/0",
               bus.t_req, bus.c_ready, bus.t_we, bus.t_addr);
    end
    bus.c_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.t_rdata1 = 32'h600DF00D;
    run_txn("after_reset", 1'b0, 32'h10000010, 32'h0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bus.t_rdata0 = 32'hAAAA0001; bus.t_rdata1 = 32'hBBBB0002; bus.t_rdata2 = 32'hCCCC0003;
    run_txn("b2b_first", 1'b0, 32'h00000200, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    run_txn("b2b_unmapped", 1'b0, 32'h40000000, 32'h0, 0, 1'b0, 1'b1, 1'b1);
    run_txn("b2b_last", 1'b1, 32'h2000000C, 32'h77, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit          prev_hold, hold, stray;
    logic        we;
    logic [31:0] a;
    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       a = $urandom & 32'h00000FFF;
        1:       a = 32'h10000000 | ($urandom & 32'h000000FF);
        2:       a = 32'h20000000 | ($urandom & 32'h0000000F);
        3:       a = 32'h20000010 | ($urandom & 32'h000000FF);
        default: a = $urandom;
      endcase
      we    = 1'($urandom);
      stray = 1'($urandom);
      hold  = (i != 39) && ($urandom_range(0, 2) == 0);
      bus.t_rdata0 = $urandom; bus.t_rdata1 = $urandom; bus.t_rdata2 = $urandom;
      run_txn("random", we, a, $urandom, $urandom_range(0, 18), stray, prev_hold, hold);
      prev_hold = hold;
    end
  endtask

  initial begin
    test_reset();
    test_load_ram();
    test_store_mmio_wait();
    test_unmapped();
    test_timeout();
    test_stray_ready();
    test_decode_boundaries();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
